// File: rtl/csub32_pipe.sv
// Two-stage pipelined carry-select subtractor: diff = a - b - bin with borrow-out and signed overflow.
// Stage 1 computes the low half and both high-half candidates; stage 2 selects the high half using the low carry.
module csub32_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int SPLIT = WIDTH / 2;

    logic             r_s1_valid;
    logic             r_c_lo;
    logic [SPLIT-1:0] r_d_lo;
    logic             r_c_h0;
    logic [SPLIT-1:0] r_h0;
    logic             r_c_h1;
    logic [SPLIT-1:0] r_h1;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_accept;
    logic [SPLIT:0]   w_lo_sum;
    logic [SPLIT:0]   w_hi_sum0;
    logic [SPLIT:0]   w_hi_sum1;
    logic [SPLIT-1:0] w_sel_hi;
    logic             w_cout;
    logic             w_ovf;

    assign w_s2_adv   = r_s1_valid & (~r_s2_valid | out_ready);
    assign w_in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept   = in_valid & w_in_ready;

    // Stage-1 arithmetic: subtraction as a + ~b + ~bin, high half speculated for both carries
    always_comb begin
        w_lo_sum  = {1'b0, a[SPLIT-1:0]} + {1'b0, ~b[SPLIT-1:0]} + {{SPLIT{1'b0}}, ~bin};
        w_hi_sum0 = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, ~b[WIDTH-1:SPLIT]};
        w_hi_sum1 = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, ~b[WIDTH-1:SPLIT]} + {{SPLIT{1'b0}}, 1'b1};
    end

    // Stage-2 carry select and overflow from the selected result sign
    always_comb begin
        w_sel_hi = r_h0;
        w_cout   = r_c_h0;
        if (r_c_lo) begin
            w_sel_hi = r_h1;
            w_cout   = r_c_h1;
        end else begin
            w_sel_hi = r_h0;
            w_cout   = r_c_h0;
        end
        w_ovf = (r_a_msb != r_b_msb) && (w_sel_hi[SPLIT-1] != r_a_msb);
    end

    // Pipeline occupancy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Stage-1 data registers, loaded only when an operation is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_lo  <= 1'b0;
            r_d_lo  <= {SPLIT{1'b0}};
            r_c_h0  <= 1'b0;
            r_h0    <= {SPLIT{1'b0}};
            r_c_h1  <= 1'b0;
            r_h1    <= {SPLIT{1'b0}};
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            {r_c_lo, r_d_lo} <= w_lo_sum;
            {r_c_h0, r_h0}   <= w_hi_sum0;
            {r_c_h1, r_h1}   <= w_hi_sum1;
            r_a_msb          <= a[WIDTH-1];
            r_b_msb          <= b[WIDTH-1];
        end
    end

    // Stage-2 result registers, loaded only when stage 1 advances so stalled results hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= {WIDTH{1'b0}};
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_adv) begin
            r_diff <= {w_sel_hi, r_d_lo};
            r_bout <= ~w_cout;
            r_ovf  <= w_ovf;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_csub32_pipe.sv
// Self-checking bench for csub32_pipe: directed vectors, backpressure, reset mid-flight and randomized traffic
// checked against an arithmetic reference model.
module tb_csub32_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    csub32_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, bout, diff} from integer arithmetic on the operand values
    function automatic logic [33:0] ref_sub(input logic [31:0] ra, input logic [31:0] rb, input logic rbin);
        longint sa, sb, sr;
        logic [63:0] ua, ub;
        logic [31:0] d;
        logic r_b, r_o;
        sa  = longint'($signed(ra));
        sb  = longint'($signed(rb));
        sr  = sa - sb - longint'(rbin);
        r_o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        ua  = {32'd0, ra};
        ub  = {32'd0, rb} + {63'd0, rbin};
        r_b = ua < ub;
        d   = ra - rb - {31'd0, rbin};
        return {r_o, r_b, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; bin = 1'b0;
        #12;
        checks++;
        if ({out_valid, bout, ovf, diff} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b bout=%b ovf=%b diff=%h, expected all zero", out_valid, bout, ovf, diff);
        end
        #11 rst_n = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    localparam logic [31:0] DA [4] = '{32'h00000005, 32'h00000000, 32'h80000000, 32'h00010000};
    localparam logic [31:0] DB [4] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h00000001};
    localparam logic        DI [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [33:0] DE [4] = '{{2'b00, 32'h00000002}, {2'b01, 32'hFFFFFFFF},
                                       {2'b10, 32'h7FFFFFFF}, {2'b00, 32'h0000FFFE}};

    task automatic test_directed();
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'b1; out_ready = 1'b1;
            a = DA[i]; b = DB[i]; bin = DI[i];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            cyc();
            in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_early_valid[%0d]: got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || {ovf, bout, diff} !== DE[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got valid=%b {ovf,bout,diff}=%h expected valid=1 %h",
                         i, out_valid, {ovf, bout, diff}, DE[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] oa [3];
        logic [31:0] ob [3];
        logic        oi [3];
        logic [33:0] ex [3];
        for (int i = 0; i < 3; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; oi[i] = 1'($urandom_range(0, 1));
            ex[i] = ref_sub(oa[i], ob[i], oi[i]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            out_ready = 1'b0; in_valid = 1'b1;
            a = oa[i]; b = ob[i]; bin = oi[i];
            @(negedge clk);
            checks++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 2));
            end
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {ovf, bout, diff} !== ex[0]) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b res=%h expected rdy=0 vld=1 res=%h",
                         k, in_ready, out_valid, {ovf, bout, diff}, ex[0]);
            end
        end
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_push_pop_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {ovf, bout, diff} !== ex[i]) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got vld=%b res=%h expected vld=1 res=%h", i, out_valid, {ovf, bout, diff}, ex[i]);
            end
            cyc();
            in_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            cyc();
            out_ready = 1'b0; in_valid = 1'b1;
            a = 32'hFFFF0000 | 32'(i + 3); b = 32'h00000001; bin = 1'b0;
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full: got vld=%b rdy=%b expected vld=1 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, bout, ovf, diff} !== 35'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: got vld=%b bout=%b ovf=%b diff=%h expected all zero", out_valid, bout, ovf, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        cyc();
        in_valid = 1'b1; out_ready = 1'b1; a = 32'd7; b = 32'd2; bin = 1'b0;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || diff !== 32'd5 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fresh: got vld=%b diff=%h bout=%b ovf=%b expected vld=1 diff=5 bout=0 ovf=0",
                     out_valid, diff, bout, ovf);
        end
        cyc();
    endtask

    task automatic test_random(input int n);
        logic [33:0] q [$];
        logic [31:0] corner [4];
        logic        exp_rdy;
        int sent = 0;
        int got  = 0;
        int cnt  = 0;
        corner = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        while (got < n && cnt < 4000) begin
            cyc();
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            bin = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy = !(q.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", cnt, in_ready, exp_rdy);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious[%0d]: got out_valid=1 expected no pending result", cnt);
                end else if ({ovf, bout, diff} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: got %h expected %h", cnt, {ovf, bout, diff}, q[0]);
                end
                if (out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sub(a, b, bin));
                sent++;
            end
            cnt++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL rand_timeout: got %0d results expected %0d", got, n);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
